// File: rtl/axi4_burst_writer_if.sv
// AXI4 write-side bundle (AW, W, B) shared by the burst writer and its slave.
interface axi4_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi4_burst_writer.sv
// Drains a FWFT FIFO into a circular memory region with variable-length AXI4 INCR
// bursts; splits at 4 KB pages and region end, flushes partial bursts on timeout/request.
module axi4_burst_writer #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned MAX_BURST     = 16,
  parameter int unsigned LEVEL_WIDTH   = 10,
  parameter int unsigned FLUSH_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic                   flush,
  input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0]  cfg_region_bytes,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  input  logic                   fifo_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_level,
  output logic                   fifo_rd_en,
  axi4_if.master                 axi4_master_if,
  output logic                   busy,
  output logic                   err,
  output logic [ADDR_WIDTH-1:0]  err_addr,
  output logic [31:0]            bursts_done
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned SIZE  = $clog2(BYTES);
  localparam int unsigned AW    = ADDR_WIDTH + 1;
  localparam int unsigned LEN_W = $clog2(MAX_BURST + 1);
  localparam int unsigned TMR_W = $clog2(FLUSH_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      beat_q, beat_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  err_q, err_d;
  logic [31:0]           bursts_q, bursts_d;

  logic [AW-1:0] to_4k_c, to_end_c, region_end_c, bnd_c, level_c, addr_nxt_c;
  logic          full_go_c, part_go_c, wvalid_c, wlast_c, w_hs_c;

  // Beats allowed from cur_addr: capped by MAX_BURST, the 4 KB page and the region end
  always_comb begin
    region_end_c = AW'(cfg_base_addr) + AW'(cfg_region_bytes);
    to_4k_c      = (AW'(4096) - AW'(cur_addr_q[11:0])) >> SIZE;
    to_end_c     = (region_end_c - AW'(cur_addr_q)) >> SIZE;
    bnd_c        = AW'(MAX_BURST);
    if (to_4k_c < bnd_c)  bnd_c = to_4k_c;
    if (to_end_c < bnd_c) bnd_c = to_end_c;
    level_c      = AW'(fifo_level);
    addr_nxt_c   = AW'(cur_addr_q) + (AW'(len_q) << SIZE);
  end

  assign full_go_c = enable && (bnd_c != '0) && (level_c >= bnd_c);
  assign part_go_c = enable && (bnd_c != '0) && !fifo_empty &&
                     (flush || (timer_q == TMR_W'(FLUSH_TIMEOUT - 1)));
  assign wvalid_c  = (state_q == S_DATA) && !fifo_empty;
  assign wlast_c   = (state_q == S_DATA) && ((beat_q + LEN_W'(1)) == len_q);
  assign w_hs_c    = wvalid_c && axi4_master_if.wready;

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    err_addr_d = err_addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    timer_d    = '0;
    err_d      = err_q;
    bursts_d   = bursts_q;

    unique case (state_q)
      S_IDLE: begin
        if (!enable) cur_addr_d = cfg_base_addr;
        if (enable && !fifo_empty && (timer_q != TMR_W'(FLUSH_TIMEOUT - 1)))
          timer_d = timer_q + TMR_W'(1);
        else if (enable && !fifo_empty)
          timer_d = timer_q;
        if (full_go_c) begin
          len_d   = LEN_W'(bnd_c);
          timer_d = '0;
          state_d = S_ADDR;
        end else if (part_go_c) begin
          len_d   = (level_c < bnd_c) ? LEN_W'(level_c) : LEN_W'(bnd_c);
          timer_d = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (axi4_master_if.awready) begin
          beat_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs_c) begin
          if (wlast_c) begin
            beat_d  = '0;
            state_d = S_RESP;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end
      S_RESP: begin
        if (axi4_master_if.bvalid) begin
          bursts_d = bursts_q + 32'd1;
          if ((axi4_master_if.bresp != 2'b00) && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = cur_addr_q;
          end
          // Wrap to base when the burst ends exactly at the region end
          if (addr_nxt_c == region_end_c) cur_addr_d = cfg_base_addr;
          else                            cur_addr_d = ADDR_WIDTH'(addr_nxt_c);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      err_addr_q <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      bursts_q   <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      err_addr_q <= err_addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      bursts_q   <= bursts_d;
    end
  end

  // AW fields come straight from registers, so they hold until AWREADY
  assign axi4_master_if.awid    = '0;
  assign axi4_master_if.awaddr  = cur_addr_q;
  assign axi4_master_if.awlen   = 8'(len_q) - 8'd1;
  assign axi4_master_if.awsize  = 3'(SIZE);
  assign axi4_master_if.awburst = 2'b01;
  assign axi4_master_if.awprot  = 3'b000;
  assign axi4_master_if.awvalid = (state_q == S_ADDR);
  assign axi4_master_if.wdata   = fifo_data;
  assign axi4_master_if.wstrb   = '1;
  assign axi4_master_if.wlast   = wlast_c;
  assign axi4_master_if.wvalid  = wvalid_c;
  assign axi4_master_if.bready  = (state_q == S_RESP);

  assign fifo_rd_en  = w_hs_c;
  assign busy        = (state_q != S_IDLE);
  assign err         = err_q;
  assign err_addr    = err_addr_q;
  assign bursts_done = bursts_q;
endmodule

// File: tb/tb_axi4_burst_writer.sv
// Directed bench for axi4_burst_writer: FIFO + AXI slave model, logged AW/W/B traffic.
module tb_axi4_burst_writer;
  localparam int unsigned AWD = 32;
  localparam int unsigned DWD = 64;
  localparam int unsigned LVW = 10;

  logic           clk = 1'b0;
  logic           rstn, enable, flush;
  logic [AWD-1:0] cfg_base_addr, cfg_region_bytes;
  logic [DWD-1:0] fifo_data;
  logic           fifo_empty;
  logic [LVW-1:0] fifo_level;
  logic           fifo_rd_en, busy, err;
  logic [AWD-1:0] err_addr;
  logic [31:0]    bursts_done;

  axi4_if #(.ADDR_WIDTH(AWD), .DATA_WIDTH(DWD), .ID_WIDTH(4)) axi ();

  axi4_burst_writer #(
    .ADDR_WIDTH(AWD), .DATA_WIDTH(DWD), .ID_WIDTH(4),
    .MAX_BURST(16), .LEVEL_WIDTH(LVW), .FLUSH_TIMEOUT(64)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .flush(flush),
    .cfg_base_addr(cfg_base_addr), .cfg_region_bytes(cfg_region_bytes),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
    .fifo_rd_en(fifo_rd_en), .axi4_master_if(axi), .busy(busy), .err(err),
    .err_addr(err_addr), .bursts_done(bursts_done)
  );

  always #5 clk = ~clk;

  // Controls written only by the stimulus block
  int  words_req = 0;
  bit  stall_mode = 1'b0;
  int  err_b_idx = -1;
  int  n_vec = 0, n_err = 0;
  int  a0 = 0, b0 = 0;

  // State written only by the FIFO/slave/monitor block
  logic [DWD-1:0] fifo_q[$];
  logic [DWD-1:0] pop_word;
  logic [AWD-1:0] aw_addr_log[$];
  logic [7:0]     aw_len_log[$];
  int             aw_cyc_log[$], b_cyc_log[$], wlast_log[$];
  logic [44:0]    prev_aw;
  bit             pop_pend = 1'b0, aw_pend = 1'b0, aw_done = 1'b0;
  int             words_added = 0, exp_idx = 0, w_beat = 0, w_total = 0, b_cnt = 0, cyc = 0;
  int             data_bad = 0, stab_bad = 0, rd_bad = 0, wv_bad = 0;

  function automatic logic [DWD-1:0] word_of(input int i);
    return {32'hC0DE0000 + 32'(i), 32'(i) ^ 32'h5A5A5A5A};
  endfunction

  // FIFO and slave drive at negedge; the monitor samples 1 ns later for the next posedge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (pop_pend) begin
      pop_word = fifo_q.pop_front();
      pop_pend = 1'b0;
    end
    while (words_added < words_req) begin
      fifo_q.push_back(word_of(words_added));
      words_added++;
    end
    fifo_empty  = (fifo_q.size() == 0) || (stall_mode && busy && ($urandom_range(0, 3) == 0));
    fifo_data   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    fifo_level  = LVW'(fifo_q.size());
    axi.awready = !stall_mode || ($urandom_range(0, 2) != 0);
    axi.wready  = !stall_mode || ($urandom_range(0, 2) != 0);
    axi.bvalid  = !stall_mode || ($urandom_range(0, 1) != 0);
    axi.bresp   = (b_cnt == err_b_idx) ? 2'b10 : 2'b00;
    #1;
    if (!rstn) begin
      aw_pend = 1'b0;
      aw_done = 1'b0;
      w_beat  = 0;
    end else begin
      if (axi.awvalid && aw_pend &&
          ({axi.awaddr, axi.awlen, axi.awsize, axi.awburst} !== prev_aw)) stab_bad++;
      aw_pend = axi.awvalid && !axi.awready;
      prev_aw = {axi.awaddr, axi.awlen, axi.awsize, axi.awburst};
      if (axi.wvalid && !aw_done) wv_bad++;
      if (fifo_rd_en !== (axi.wvalid && axi.wready)) rd_bad++;
      if (axi.awvalid && axi.awready) begin
        aw_addr_log.push_back(axi.awaddr);
        aw_len_log.push_back(axi.awlen);
        aw_cyc_log.push_back(cyc);
        aw_done = 1'b1;
        w_beat  = 0;
      end
      if (axi.wvalid && axi.wready) begin
        if (axi.wdata !== word_of(exp_idx)) data_bad++;
        exp_idx++;
        w_total++;
        pop_pend = 1'b1;
        if (axi.wlast) begin
          wlast_log.push_back(w_beat);
          aw_done = 1'b0;
          w_beat  = 0;
        end else begin
          w_beat++;
        end
      end
      if (axi.bvalid && axi.bready) begin
        b_cyc_log.push_back(cyc);
        b_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_bursts(input int target, input int budget, input string tag);
    int k = 0;
    while ((bursts_done != 32'(target)) && (k < budget)) begin
      tick(1);
      k++;
    end
    check(tag, 64'(bursts_done), 64'(target));
  endtask

  task automatic run_region(input logic [AWD-1:0] base, input logic [AWD-1:0] size, input int words);
    enable = 1'b0;
    tick(2);
    cfg_base_addr    = base;
    cfg_region_bytes = size;
    words_req        = words_req + words;
    tick(2);
    a0 = aw_addr_log.size();
    b0 = b_cyc_log.size();
    enable = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".awvalid"}, 64'(axi.awvalid), 64'd0);
    check({tag, ".wvalid"},  64'(axi.wvalid),  64'd0);
    check({tag, ".bready"},  64'(axi.bready),  64'd0);
    check({tag, ".rd_en"},   64'(fifo_rd_en),  64'd0);
    check({tag, ".busy"},    64'(busy),        64'd0);
    check({tag, ".err"},     64'(err),         64'd0);
    check({tag, ".err_addr"}, 64'(err_addr),   64'd0);
    check({tag, ".bursts"},  64'(bursts_done), 64'd0);
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b0; flush = 1'b0;
    cfg_base_addr = '0; cfg_region_bytes = 32'h100;
    tick(3);
    check_reset_outputs("rst0");
    check("rst0.awaddr", 64'(axi.awaddr), 64'd0);
    rstn = 1'b1;
    tick(1);

    // Two full bursts, then the 8-word remainder leaves on the timeout
    run_region(32'h1000, 32'h400, 40);
    wait_bursts(3, 400, "t1.bursts");
    check("t1.aw0", 64'(aw_addr_log[a0]),   64'h1000);
    check("t1.aw1", 64'(aw_addr_log[a0+1]), 64'h1080);
    check("t1.aw2", 64'(aw_addr_log[a0+2]), 64'h1100);
    check("t1.len2", 64'(aw_len_log[a0+2]), 64'd7);
    check("t1.last0", 64'(wlast_log[a0]),   64'd15);
    check("t1.last1", 64'(wlast_log[a0+1]), 64'd15);
    check("t1.last2", 64'(wlast_log[a0+2]), 64'd7);
    check("t1.timeout_gap", 64'(aw_cyc_log[a0+2] - b_cyc_log[b0+1]), 64'd65);

    // Region wrap: the third burst returns to base
    run_region(32'h0, 32'h100, 48);
    wait_bursts(6, 300, "t2.bursts");
    check("t2.aw0", 64'(aw_addr_log[a0]),   64'h0);
    check("t2.aw1", 64'(aw_addr_log[a0+1]), 64'h80);
    check("t2.aw2", 64'(aw_addr_log[a0+2]), 64'h0);

    // Page split: 0xFC0 leaves 8 beats before the 4 KB boundary
    run_region(32'h0FC0, 32'h1000, 32);
    wait_bursts(9, 400, "t3.bursts");
    check("t3.aw0",  64'(aw_addr_log[a0]),   64'h0FC0);
    check("t3.len0", 64'(aw_len_log[a0]),    64'd7);
    check("t3.aw1",  64'(aw_addr_log[a0+1]), 64'h1000);
    check("t3.len1", 64'(aw_len_log[a0+1]),  64'd15);
    check("t3.aw2",  64'(aw_addr_log[a0+2]), 64'h1080);
    check("t3.len2", 64'(aw_len_log[a0+2]),  64'd7);

    // Backpressure and FIFO gaps
    stall_mode = 1'b1;
    run_region(32'h2000, 32'h800, 48);
    wait_bursts(12, 3000, "t4.bursts");
    stall_mode = 1'b0;
    check("t4.aw0", 64'(aw_addr_log[a0]),   64'h2000);
    check("t4.aw1", 64'(aw_addr_log[a0+1]), 64'h2080);
    check("t4.aw2", 64'(aw_addr_log[a0+2]), 64'h2100);
    check("t4.aw_stable", 64'(stab_bad), 64'd0);
    check("t4.pop_vs_hs", 64'(rd_bad),   64'd0);
    check("t4.wv_early",  64'(wv_bad),   64'd0);
    check("t4.data_order", 64'(data_bad), 64'd0);
    check("t4.w_total",   64'(w_total),  64'd168);

    // SLVERR on the second burst, OKAY on the third
    err_b_idx = b_cnt + 1;
    run_region(32'h3000, 32'h1000, 48);
    wait_bursts(14, 300, "t5.bursts2");
    check("t5.err",      64'(err),      64'd1);
    check("t5.err_addr", 64'(err_addr), 64'h3080);
    wait_bursts(15, 300, "t5.bursts3");
    check("t5.err_sticky",  64'(err),      64'd1);
    check("t5.err_addr_kept", 64'(err_addr), 64'h3080);

    // Flush with 3 words: AW must appear the next cycle
    words_req = words_req + 3;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("fl.awvalid", 64'(axi.awvalid), 64'd1);
    check("fl.awlen",   64'(axi.awlen),   64'd2);
    check("fl.awaddr",  64'(axi.awaddr),  64'h3180);
    check("fl.awsize",  64'(axi.awsize),  64'd3);
    check("fl.awburst", 64'(axi.awburst), 64'd1);
    check("fl.awprot",  64'(axi.awprot),  64'd0);
    check("fl.awid",    64'(axi.awid),    64'd0);
    check("fl.wstrb",   64'(axi.wstrb),   64'hFF);
    wait_bursts(16, 100, "fl.bursts");

    // Reset after 5 beats of a 16-beat burst
    run_region(32'h4000, 32'h1000, 16);
    begin
      int k = 0;
      while ((w_beat != 5) && (k < 100)) begin
        tick(1);
        k++;
      end
      check("t6.reach5", 64'(w_beat), 64'd5);
    end
    rstn   = 1'b0;
    enable = 1'b0;
    tick(1);
    check_reset_outputs("t6.rst");
    rstn = 1'b1;
    tick(2);
    a0 = aw_addr_log.size();
    enable = 1'b1;
    wait_bursts(1, 300, "t6.bursts");
    check("t6.aw0",  64'(aw_addr_log[a0]), 64'h4000);
    check("t6.len0", 64'(aw_len_log[a0]),  64'd10);
    check("t6.data_order", 64'(data_bad), 64'd0);
    check("t6.pop_vs_hs",  64'(rd_bad),   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end
endmodule
